// File: rtl/ahb_slave_mem.sv
`default_nettype none
// ============================================================================
// ahb_slave_mem : AHB word memory slave, programmable wait states, ERROR resp
// Rev 1.0
// ============================================================================
module ahb_slave_mem #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int unsigned c_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  c_WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    LAST = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } state_t;

  state_t          r_state;
  logic [2:0]      r_cnt;
  logic            r_write;
  logic [c_AW-1:0] r_index;
  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_hrdata;
  logic            r_hready;
  logic            r_hresp;

  logic            w_accept;
  logic            w_illegal;
  logic            w_commit;
  logic [c_AW-1:0] w_index;
  logic [31:0]     w_fwd_rdata;
  logic            w_unused;

  assign w_index   = HADDR[c_AW+1:2];
  assign w_illegal = (HADDR[1:0] != 2'b00) || (HADDR[31:c_AW+2] != '0);
  assign w_accept  = HSEL && HTRANS[1] && r_hready && ((r_state == IDLE) || (r_state == LAST));
  assign w_commit  = (r_state == LAST) && r_write;
  // A zero-wait read can land on the edge that commits the preceding write
  assign w_fwd_rdata = (w_commit && (r_index == w_index)) ? HWDATA : r_mem[w_index];
  assign w_unused  = HTRANS[0];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_write  <= 1'b0;
      r_index  <= '0;
      r_hready <= 1'b1;
      r_hresp  <= 1'b0;
      r_hrdata <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_commit) begin
        r_mem[r_index] <= HWDATA;
      end
      r_hrdata <= '0;
      r_hresp  <= 1'b0;
      r_hready <= 1'b1;
      case (r_state)
        IDLE, LAST: begin
          if (w_accept) begin
            r_write <= HWRITE;
            r_index <= w_index;
            if (w_illegal) begin
              r_state  <= ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              r_state  <= WAIT;
              r_cnt    <= c_WS_LOAD;
              r_hready <= 1'b0;
            end else begin
              r_state <= LAST;
              if (!HWRITE) begin
                r_hrdata <= w_fwd_rdata;
              end
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= LAST;
            if (!r_write) begin
              r_hrdata <= r_mem[r_index];
            end
          end else begin
            r_cnt    <= r_cnt - 3'd1;
            r_hready <= 1'b0;
          end
        end
        ERR1: begin
          r_state <= ERR2;
          r_hresp <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign HRDATA = r_hrdata;
  assign HREADY = r_hready;
  assign HRESP  = r_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// tb_ahb_slave_mem : scoreboard bench; unit 0 runs WAIT_STATES=0, unit 1 runs WAIT_STATES=1
module tb_ahb_slave_mem;

  localparam int DEPTH = 16;

  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r_rst   [2];
  logic        r_sel   [2];
  logic [31:0] r_addr  [2];
  logic [1:0]  r_trans [2];
  logic        r_write [2];
  logic [31:0] r_wdata [2];
  logic [31:0] w_rdata [2];
  logic        w_ready [2];
  logic        w_resp  [2];

  ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(r_rst[0]), .HSEL(r_sel[0]), .HADDR(r_addr[0]),
    .HTRANS(r_trans[0]), .HWRITE(r_write[0]), .HWDATA(r_wdata[0]),
    .HRDATA(w_rdata[0]), .HREADY(w_ready[0]), .HRESP(w_resp[0])
  );

  ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_dut1 (
    .HCLK(clk), .HRESET(r_rst[1]), .HSEL(r_sel[1]), .HADDR(r_addr[1]),
    .HTRANS(r_trans[1]), .HWRITE(r_write[1]), .HWDATA(r_wdata[1]),
    .HRDATA(w_rdata[1]), .HREADY(w_ready[1]), .HRESP(w_resp[1])
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [2][DEPTH];
  exp_t q0[$];
  exp_t q1[$];

  bit in_data [2];
  int dcyc    [2];
  bit rst_q   [2];

  function automatic void check(string name, int u, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s unit%0d actual=%h required=%h t=%0t", name, u, act, exp, $time);
    end
  endfunction

  function automatic int qsize(int u);
    if (u == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic exp_t qpeek(int u);
    if (u == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic void qpop(int u);
    if (u == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endfunction

  function automatic void qpush(int u, exp_t e);
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic void qclear(int u);
    if (u == 0) q0.delete();
    else q1.delete();
  endfunction

  // Monitor: runs at every falling edge, independent of the stimulus
  function automatic void mon(int u);
    exp_t e;
    if (rst_q[u]) begin
      check("reset_hready", u, 32'(w_ready[u]), 32'd1);
      check("reset_hresp", u, 32'(w_resp[u]), 32'd0);
      check("reset_hrdata", u, w_rdata[u], 32'd0);
      in_data[u] = 1'b0;
    end else if (in_data[u]) begin
      dcyc[u]++;
      if (qsize(u) == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow unit%0d actual=empty required=entry t=%0t", u, $time);
        in_data[u] = 1'b0;
      end else begin
        e = qpeek(u);
        if (w_ready[u]) begin
          qpop(u);
          check("done_hresp", u, 32'(w_resp[u]), 32'(e.err));
          check("done_hrdata", u, w_rdata[u], (e.err || e.wr) ? 32'd0 : e.rdata);
          check("latency", u, 32'(dcyc[u]), 32'(e.lat));
          in_data[u] = 1'b0;
        end else begin
          check("wait_hresp", u, 32'(w_resp[u]), 32'(e.err));
          check("wait_hrdata", u, w_rdata[u], 32'd0);
        end
      end
    end else begin
      check("idle_hready", u, 32'(w_ready[u]), 32'd1);
      check("idle_hresp", u, 32'(w_resp[u]), 32'd0);
      check("idle_hrdata", u, w_rdata[u], 32'd0);
    end
    if (!r_rst[u] && r_sel[u] && r_trans[u][1] && w_ready[u] && !w_resp[u]) begin
      in_data[u] = 1'b1;
      dcyc[u]    = 0;
    end
    rst_q[u] = r_rst[u];
  endfunction

  always @(negedge clk) mon(0);
  always @(negedge clk) mon(1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int u, input logic sel, input logic [1:0] trans,
                     input logic [31:0] addr, input logic wr, input int n);
    r_sel[u]   = sel;
    r_trans[u] = trans;
    r_addr[u]  = addr;
    r_write[u] = wr;
    repeat (n) tick();
  endtask

  task automatic idle(input int u, input int n);
    nop(u, 1'b0, 2'b00, 32'd0, 1'b0, n);
  endtask

  task automatic do_reset(input int u, input int n);
    r_rst[u]   = 1'b1;
    r_sel[u]   = 1'b0;
    r_trans[u] = 2'b00;
    repeat (n) tick();
    r_rst[u] = 1'b0;
    qclear(u);
    for (int i = 0; i < DEPTH; i++) model[u][i] = 32'd0;
  endtask

  // Address phase held until the slave takes it; expectation pushed on acceptance
  task automatic xfer(input int u, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    bit   acc;
    int   n;
    int   idx;
    exp_t e;
    r_sel[u]   = 1'b1;
    r_trans[u] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    r_addr[u]  = addr;
    r_write[u] = wr;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 32) begin
      @(negedge clk);
      acc = w_ready[u] && !w_resp[u] && !r_rst[u];
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout unit%0d addr=%h actual=%0d cycles required=<32", u, addr, n);
    end else begin
      e.err   = (addr[1:0] != 2'b00) || (addr[31:6] != 26'd0);
      e.wr    = wr;
      e.lat   = e.err ? 2 : u + 1;
      e.rdata = 32'd0;
      idx     = int'(addr[5:2]);
      if (!e.err) begin
        if (wr) model[u][idx] = wdata;
        else e.rdata = model[u][idx];
      end
      qpush(u, e);
      r_wdata[u] = wdata;
    end
  endtask

  task automatic rand_run(input int u, input int n);
    logic [31:0] addr;
    logic [1:0]  tr;
    logic        s;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        1:       addr = ($urandom() | 32'h40) & 32'hFFFF_FFFC;
        default: addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      xfer(u, addr, 1'($urandom_range(0, 1)), $urandom());
      if ($urandom_range(0, 2) == 0) begin
        s  = 1'($urandom_range(0, 1));
        tr = s ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        nop(u, s, tr, 32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)),
            $urandom_range(1, 2));
      end
    end
    idle(u, 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      r_rst[u]   = 1'b1;
      r_sel[u]   = 1'b0;
      r_addr[u]  = 32'd0;
      r_trans[u] = 2'b00;
      r_write[u] = 1'b0;
      r_wdata[u] = 32'd0;
      rst_q[u]   = 1'b1;
      in_data[u] = 1'b0;
      dcyc[u]    = 0;
      for (int i = 0; i < DEPTH; i++) model[u][i] = 32'd0;
    end
    repeat (3) tick();
    r_rst[0] = 1'b0;
    r_rst[1] = 1'b0;
    idle(0, 2);

    // One wait state: write then read the same word
    xfer(1, 32'h08, 1'b1, 32'hDEADBEEF);
    xfer(1, 32'h08, 1'b0, 32'd0);
    idle(1, 3);

    // Zero wait states: back-to-back write then read through the forwarding path
    xfer(0, 32'h04, 1'b1, 32'h11111111);
    xfer(0, 32'h04, 1'b0, 32'd0);
    idle(0, 3);

    // Illegal addresses, then a clean read of word 0
    xfer(1, 32'h40, 1'b0, 32'd0);
    xfer(1, 32'h06, 1'b1, 32'hBAD0BAD0);
    xfer(1, 32'h00, 1'b0, 32'd0);
    idle(1, 3);

    // BUSY and deselected writes leave word 3 untouched
    xfer(1, 32'h0C, 1'b1, 32'hA5A5_5A5A);
    idle(1, 2);
    r_wdata[1] = 32'hFFFF_0000;
    nop(1, 1'b1, 2'b01, 32'h0C, 1'b1, 3);
    nop(1, 1'b0, 2'b10, 32'h0C, 1'b1, 3);
    xfer(1, 32'h0C, 1'b0, 32'd0);
    idle(1, 3);

    // Reset while the write sits in its wait cycle
    xfer(1, 32'h10, 1'b1, 32'h12345678);
    do_reset(1, 2);
    xfer(1, 32'h10, 1'b0, 32'd0);
    idle(1, 3);

    rand_run(0, 200);
    rand_run(1, 200);

    check("sb_drain", 0, 32'(qsize(0)), 32'd0);
    check("sb_drain", 1, 32'(qsize(1)), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
- REQ-001: The block SHALL have parameter DEPTH, default 16, meaning the number of 32-bit words of storage (power of 2, 2..256).
- REQ-002: The block SHALL have parameter WAIT_STATES, default 1, meaning the number of HREADY-low cycles inserted in each OKAY data phase (0..7).
- REQ-003: The block SHALL have port HCLK, input, 1 bit, meaning the single clock; all logic is on its rising edge.
- REQ-004: The block SHALL have port HRESET, input, 1 bit, meaning reset; it is synchronous and active-high.
- REQ-005: The block SHALL have port HSEL, input, 1 bit, meaning slave select.
- REQ-006: The block SHALL have port HADDR, input, 32 bits, meaning the address-phase byte address.
- REQ-007: The block SHALL have port HTRANS, input, 2 bits, meaning IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- REQ-008: The block SHALL have port HWRITE, input, 1 bit, meaning 1=write, 0=read, sampled in the address phase.
- REQ-009: The block SHALL have port HWDATA, input, 32 bits, meaning write data, sampled in the data phase.
- REQ-010: The block SHALL have port HRDATA, output, 32 bits, meaning read data, valid when HREADY=1 in a read data phase.
- REQ-011: The block SHALL have port HREADY, output, 1 bit, meaning transfer complete / bus ready.
- REQ-012: The block SHALL have port HRESP, output, 1 bit, meaning 0=OKAY, 1=ERROR.

Function
- REQ-013: The block SHALL accept an address phase when HSEL=1, HTRANS[1]=1 and HREADY=1 at a rising edge, capturing HADDR, HWRITE and the word index HADDR[log2(DEPTH)+1:2].
- REQ-014: The block SHALL ignore HTRANS IDLE and BUSY, and any cycle with HSEL=0; these produce no storage access and an OKAY zero-wait response (HREADY=1, HRESP=0).
- REQ-015: The FSM SHALL have exactly the states IDLE, WAIT, LAST, ERR1 and ERR2.
- REQ-016: From IDLE or LAST, an accepted legal transfer SHALL go to WAIT when WAIT_STATES>0, otherwise to LAST; an accepted illegal transfer SHALL go to ERR1; no acceptance SHALL go to IDLE.
- REQ-017: In WAIT, the block SHALL drive HREADY=0 and HRESP=0, decrement a 3-bit counter loaded with WAIT_STATES-1, and go to LAST when the counter reaches 0.
- REQ-018: In LAST, the block SHALL drive HREADY=1 and HRESP=0; a write SHALL commit HWDATA to mem[index] at the closing edge, and a read SHALL drive HRDATA=mem[index].
- REQ-019: A transfer SHALL be illegal if HADDR[1:0]!=0 or HADDR[31:log2(DEPTH)+2]!=0.
- REQ-020: An illegal transfer SHALL give a two-cycle ERROR: ERR1 drives HREADY=0, HRESP=1; ERR2 drives HREADY=1, HRESP=1; storage SHALL NOT be modified.
- REQ-021: ERR2 SHALL go to IDLE and SHALL NOT accept a new address phase.
- REQ-022: Pipelining: the block SHALL accept the next address phase in the LAST cycle of the current transfer, giving back-to-back transfers with no idle cycle.
- REQ-023: Read-after-write: a read of a word whose write committed at the previous edge SHALL return the new data, including when WAIT_STATES=0.
- REQ-024: In IDLE, WAIT and ERR states, and in write data phases, HRDATA SHALL be 0.
- REQ-025: Total latency SHALL be 1 address cycle plus WAIT_STATES+1 data cycles for OKAY transfers, and 1 address cycle plus 2 data cycles for ERROR transfers.

Reset
- REQ-026: While HRESET=1 at a rising edge, the block SHALL go to IDLE with HREADY=1, HRESP=0, HRDATA=0, the wait counter at 0 and every storage word at 0.
- REQ-027: Reset asserted mid-transfer (WAIT or ERR1) SHALL abort the transfer with no write committed; the first cycle after reset release is IDLE.

Verification
- REQ-028: WAIT_STATES=1; write 0xDEADBEEF to 0x08, then read 0x08 -> write data phase shows HREADY 0,1; read returns HRDATA=0xDEADBEEF in its LAST cycle.
- REQ-029: WAIT_STATES=0; back-to-back NONSEQ write 0x04=0x11111111, then read 0x04 -> no HREADY-low cycle; read returns 0x11111111.
- REQ-030: Read 0x40 (DEPTH=16) or 0x06 -> HREADY/HRESP sequence (0,1) then (1,1); mem unchanged; next read of 0x00 returns 0.
- REQ-031: HTRANS=BUSY or HSEL=0 with HWRITE=1 to 0x0C -> HREADY stays 1, HRESP=0, mem[3] unchanged.
- REQ-032: Assert HRESET during the WAIT cycle of a write of 0x12345678 to 0x10 -> outputs reach reset values; a subsequent read of 0x10 returns 0.
